arb_out_stage: RTL and testbench
================================

// Module: arb_out_stage
// PURPOSE
//  Downstream consumer of the round-robin arbiter's one-hot grant. Muxes the granted
//  requester's data beat into a 2-entry output buffer with valid/ready handshake,
//  acks the winner, and holds the channel locked to one source until its last beat.
//  Drives arb_ready back to the arbiter's ready_in so the priority pointer only
//  advances on an accepted packet head.
// PARAMETERS
//  REQ_WIDTH   4   number of requesters; matches arbiter REQ_WIDTH
//  DATA_WIDTH  32  payload bits per beat
//  SRC_W       $clog2(REQ_WIDTH) (min 1)  width of out_src; derived, not overridden
// PORTS
//  clk        in   1                     clock, rising edge
//  rst_n      in   1                     asynchronous, active-low reset
//  req_valid  in   REQ_WIDTH             per-source beat valid; also the arbiter's req
//  req_data   in   REQ_WIDTH*DATA_WIDTH  source i occupies [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last   in   REQ_WIDTH             per-source last-beat-of-packet flag
//  grant      in   REQ_WIDTH             one-hot grant from arbiter (combinational)
//  arb_ready  out  1                     to arbiter ready_in; high = head beat may be taken
//  req_ack    out  REQ_WIDTH             one-hot, 1 cycle: beat of source i accepted
//  out_valid  out  1                     buffer head valid
//  out_data   out  DATA_WIDTH            buffer head payload
//  out_src    out  SRC_W                 source index of head beat
//  out_last   out  1                     head beat is last of packet
//  out_ready  in   1                     downstream accepts head when out_valid&out_ready
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, lock_src=0, fifo count=0; out_valid=0,
//   out_data/out_src/out_last=0, req_ack=0. arb_ready=1 right after release.
//   Reset mid-packet discards buffered beats and the lock; no ack is issued.
//  full = (count==2). arb_ready = (state==IDLE) & ~full. Registered terms only, so
//   there is no combinational path from out_ready to arb_ready or req_ack.
//  IDLE: sel = index of lowest set grant bit (grant is nominally one-hot; extra bits
//   ignored). Push when arb_ready & |grant & req_valid[sel]. On push: req_ack[sel]=1
//   in the same cycle (comb), entry {data,sel,last}=source sel written at the edge.
//   If req_last[sel]=0, go LOCKED with lock_src=sel; otherwise stay IDLE.
//   grant bit set with req_valid[sel]=0: no push, no ack.
//  LOCKED: grant ignored, arb_ready=0. Push when ~full & req_valid[lock_src];
//   req_ack[lock_src]=1. Push with req_last=1 returns to IDLE next cycle.
//  FIFO: 2 entries, head drives out_*. Pop when out_valid & out_ready. Push and pop
//   in the same cycle when count==1: count unchanged, order preserved. When count==2,
//   push is blocked even if a pop occurs that cycle (full is registered).
//  Latency: accepted beat appears on out_* the next cycle when the buffer was empty.
//   Sustained throughput is 1 beat/cycle while out_ready=1.
//  Single-beat packets (last=1 on head) never enter LOCKED. Arbiter pointer moves only
//   on head beats, so each packet counts as one arbitration.
//  out_* hold stable while out_valid & ~out_ready.
// STRUCTURE
//  arb_pkg: localparam state encoding (IDLE=1'b0, LOCKED=1'b1) and a clog2 function
//   shared with the arbiter-side blocks.
//  Sub-module skid_fifo2 (2-entry, width DATA_WIDTH+SRC_W+1, push/pop/full/empty).
//   The top level holds the FSM, lock register, the lowest-bit select and the data mux.
// TESTING
//  1 Reset: rst_n low mid-cycle -> out_valid=0 immediately; after release arb_ready=1,
//    req_ack=0.
//  2 Single beat: grant=4'b0100, req_valid[2]=1, last=1, data=0xA5 -> req_ack=4'b0100
//    that cycle; next cycle out_valid=1, out_data=0xA5, out_src=2, out_last=1.
//  3 Lock: src1 sends 3-beat packet while grant moves to 4'b1000 -> arb_ready=0 on
//    beats 2-3, all three beats carry out_src=1, src3 is acked only after src1's last.
//  4 Backpressure: out_ready=0, two beats pushed -> count=2, arb_ready=0, 3rd beat not
//    acked. out_ready=1 for 1 cycle -> one pop; push resumes the following cycle.
//  5 Streaming: out_ready=1, 4 sources each 1-beat, rotating grants -> 4 beats on 4
//    consecutive cycles in grant order, no bubbles.
//  6 Edge cases: grant=4'b0010 with req_valid[1]=0 -> no ack, no push. Reset asserted
//    while LOCKED -> state=IDLE and count=0 after release.

Source files
------------

// File: rtl/arb_out_stage_pkg.sv
// Shared types for the arbiter output path: channel state encoding and a width helper.
package arb_out_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/arb_out_stage_if.sv
// Requester-side and downstream-side signals of the arbiter output stage.
interface arb_out_stage_if
    import arb_out_stage_pkg::*;
#(
    parameter int REQ_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int SRC_W = clog2_min1(REQ_WIDTH);

    logic [REQ_WIDTH-1:0]            req_valid;
    logic [REQ_WIDTH*DATA_WIDTH-1:0] req_data;
    logic [REQ_WIDTH-1:0]            req_last;
    logic [REQ_WIDTH-1:0]            grant;
    logic                            arb_ready;
    logic [REQ_WIDTH-1:0]            req_ack;
    logic                            out_valid;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [SRC_W-1:0]                out_src;
    logic                            out_last;
    logic                            out_ready;

    modport slave (
        input  req_valid, req_data, req_last, grant, out_ready,
        output arb_ready, req_ack, out_valid, out_data, out_src, out_last
    );

    modport master (
        output req_valid, req_data, req_last, grant, out_ready,
        input  arb_ready, req_ack, out_valid, out_data, out_src, out_last
    );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO; head visible on dout the cycle after a push into an empty buffer.
// Push ignored when full, pop ignored when empty; full/empty are registered count decodes.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_out_stage.sv
// Takes the granted source's beat into a 2-entry buffer, acks it, and locks to that source until last.
// One-cycle latency into an empty buffer; arb_ready/req_ack depend only on registered state, never on out_ready.
module arb_out_stage
    import arb_out_stage_pkg::*;
#(
    parameter int REQ_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    arb_out_stage_if.slave bus
);
    localparam int SRC_W = clog2_min1(REQ_WIDTH);
    localparam int FW    = DATA_WIDTH + SRC_W + 1;

    state_t                state;
    state_t                state_nxt;
    logic [SRC_W-1:0]      lock_src;
    logic [SRC_W-1:0]      lock_src_nxt;
    logic [SRC_W-1:0]      sel;
    logic [SRC_W-1:0]      cur_src;
    logic [DATA_WIDTH-1:0] push_dat;
    logic                  push_last;
    logic                  src_vld;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic                  arb_ready;
    logic [FW-1:0]         head;

    // Lowest set grant bit wins; extra grant bits are ignored.
    always_comb begin
        sel = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
            if (bus.grant[i]) sel = SRC_W'(i);
        end
    end

    assign arb_ready     = (state == IDLE) & ~full;
    assign bus.arb_ready = arb_ready;

    always_comb begin
        cur_src   = (state == LOCKED) ? lock_src : sel;
        push_dat  = '0;
        push_last = 1'b0;
        src_vld   = 1'b0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (cur_src == SRC_W'(i)) begin
                push_dat  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                push_last = bus.req_last[i];
                src_vld   = bus.req_valid[i];
            end
        end
    end

    always_comb begin
        push = (state == IDLE) ? (arb_ready & (|bus.grant) & src_vld) : (~full & src_vld);
        for (int i = 0; i < REQ_WIDTH; i++) begin
            bus.req_ack[i] = push & (cur_src == SRC_W'(i));
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_src_nxt = lock_src;
        if (push) begin
            if (state == IDLE && !push_last) begin
                state_nxt    = LOCKED;
                lock_src_nxt = sel;
            end else if (state == LOCKED && push_last) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_src <= '0;
        end else begin
            state    <= state_nxt;
            lock_src <= lock_src_nxt;
        end
    end

    skid_fifo2 #(.W(FW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (~empty & bus.out_ready),
        .din   ({push_dat, cur_src, push_last}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid = ~empty;
    assign bus.out_data  = head[FW-1 -: DATA_WIDTH];
    assign bus.out_src   = head[SRC_W:1];
    assign bus.out_last  = head[0];

endmodule

// File: tb/tb_arb_out_stage.sv
// Directed bench for arb_out_stage: queue-level reference model plus literal spot checks.
module tb_arb_out_stage;
    localparam int RW = 4;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arb_out_stage_if #(.REQ_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

    arb_out_stage #(.REQ_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            s;
        bit            l;
    } beat_t;

    beat_t mq[$];
    bit    m_locked;
    int    m_src;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [RW-1:0] g);
        for (int i = 0; i < RW; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Reference: packet-level buffer of at most two beats, locked channel tracked as a flag.
    always @(negedge clk) begin
        bit            exp_rdy;
        bit            do_push;
        int            s;
        logic [RW-1:0] exp_ack;
        beat_t         e;
        if (!rst_n) begin
            mq.delete();
            m_locked = 0;
            m_src    = 0;
        end else begin
            exp_rdy = !m_locked && (mq.size() < 2);
            do_push = 0;
            s       = 0;
            if (!m_locked) begin
                if (exp_rdy && bus.grant != '0) begin
                    s       = lowest(bus.grant);
                    do_push = bus.req_valid[s];
                end
            end else begin
                s       = m_src;
                do_push = (mq.size() < 2) && bus.req_valid[s];
            end
            exp_ack = do_push ? RW'(1 << s) : '0;
            chk("model_arb_ready", 64'(bus.arb_ready), 64'(exp_rdy));
            chk("model_req_ack", 64'(bus.req_ack), 64'(exp_ack));
            chk("model_out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("model_out_data", 64'(bus.out_data), 64'(mq[0].d));
                chk("model_out_src", 64'(bus.out_src), 64'(mq[0].s));
                chk("model_out_last", 64'(bus.out_last), 64'(mq[0].l));
            end
            if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
            if (do_push) begin
                e.d = bus.req_data[s*DW +: DW];
                e.s = s;
                e.l = bus.req_last[s];
                mq.push_back(e);
                if (!m_locked && !e.l) begin
                    m_locked = 1;
                    m_src    = s;
                end else if (m_locked && e.l) begin
                    m_locked = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [RW-1:0] g, input logic [RW-1:0] v, input logic [RW-1:0] l);
        bus.grant     = g;
        bus.req_valid = v;
        bus.req_last  = l;
    endtask

    task automatic set_beat(input int s, input logic [DW-1:0] d);
        bus.req_data[s*DW +: DW] = d;
    endtask

    task automatic idle(input int n);
        drive('0, '0, '0);
        bus.out_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        drive('0, '0, '0);

        // Reset release
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_arb_ready", 64'(bus.arb_ready), 64'd1);
        chk("rst_req_ack", 64'(bus.req_ack), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);

        // Single beat
        step();
        set_beat(2, 32'hA5);
        drive(4'b0100, 4'b0100, 4'b0100);
        @(negedge clk);
        chk("single_ack", 64'(bus.req_ack), 64'h4);
        step();
        drive('0, '0, '0);
        @(negedge clk);
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_data", 64'(bus.out_data), 64'hA5);
        chk("single_src", 64'(bus.out_src), 64'd2);
        chk("single_last", 64'(bus.out_last), 64'd1);
        idle(2);

        // Lock: src1 three beats while grant moves to src3
        set_beat(1, 32'h11);
        set_beat(3, 32'h33);
        drive(4'b0010, 4'b1010, 4'b1000);
        @(negedge clk);
        chk("lock_b1_ack", 64'(bus.req_ack), 64'h2);
        step();
        set_beat(1, 32'h12);
        drive(4'b1000, 4'b1010, 4'b1000);
        @(negedge clk);
        chk("lock_b2_rdy", 64'(bus.arb_ready), 64'd0);
        chk("lock_b2_ack", 64'(bus.req_ack), 64'h2);
        chk("lock_b2_head_src", 64'(bus.out_src), 64'd1);
        step();
        set_beat(1, 32'h13);
        drive(4'b1000, 4'b1010, 4'b1010);
        @(negedge clk);
        chk("lock_b3_rdy", 64'(bus.arb_ready), 64'd0);
        chk("lock_b3_ack", 64'(bus.req_ack), 64'h2);
        step();
        drive(4'b1000, 4'b1000, 4'b1000);
        @(negedge clk);
        chk("lock_src3_ack", 64'(bus.req_ack), 64'h8);
        chk("lock_b3_out", 64'(bus.out_data), 64'h13);
        step();
        idle(3);

        // Backpressure
        bus.out_ready = 1'b0;
        set_beat(0, 32'h40);
        drive(4'b0001, 4'b0001, 4'b0001);
        @(negedge clk);
        chk("bp_ack1", 64'(bus.req_ack), 64'h1);
        step();
        set_beat(0, 32'h41);
        @(negedge clk);
        chk("bp_ack2", 64'(bus.req_ack), 64'h1);
        step();
        set_beat(0, 32'h42);
        @(negedge clk);
        chk("bp_full_rdy", 64'(bus.arb_ready), 64'd0);
        chk("bp_full_ack", 64'(bus.req_ack), 64'd0);
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_cycle_ack", 64'(bus.req_ack), 64'd0);
        chk("bp_pop_head", 64'(bus.out_data), 64'h40);
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_resume_rdy", 64'(bus.arb_ready), 64'd1);
        chk("bp_resume_ack", 64'(bus.req_ack), 64'h1);
        chk("bp_resume_head", 64'(bus.out_data), 64'h41);
        step();
        idle(4);

        // Streaming, rotating grants
        for (int i = 0; i < RW; i++) set_beat(i, 32'h50 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            if (i < RW) drive(RW'(1 << i), 4'b1111, 4'b1111);
            else        drive('0, '0, '0);
            @(negedge clk);
            if (i >= 1 && i <= RW) begin
                chk("stream_valid", 64'(bus.out_valid), 64'd1);
                chk("stream_data", 64'(bus.out_data), 64'h50 + 64'(i - 1));
            end
            step();
        end
        idle(2);

        // Grant without valid
        drive(4'b0010, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("novld_ack", 64'(bus.req_ack), 64'd0);
        step();
        drive('0, '0, '0);
        @(negedge clk);
        chk("novld_out_valid", 64'(bus.out_valid), 64'd0);
        step();

        // Reset while locked
        set_beat(2, 32'h60);
        drive(4'b0100, 4'b0100, 4'b0000);
        step();
        set_beat(2, 32'h61);
        drive(4'b0000, 4'b0100, 4'b0000);
        step();
        drive('0, '0, '0);
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        set_beat(1, 32'h66);
        drive(4'b0010, 4'b0010, 4'b0010);
        @(negedge clk);
        chk("postrst_rdy", 64'(bus.arb_ready), 64'd1);
        chk("postrst_ack", 64'(bus.req_ack), 64'h2);
        step();
        drive('0, '0, '0);
        @(negedge clk);
        chk("postrst_head_data", 64'(bus.out_data), 64'h66);
        chk("postrst_head_src", 64'(bus.out_src), 64'd1);
        step();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
